fpu_result_queue: RTL and testbench

- Sits directly downstream of the FPU top level.
- Captures each completed FPU result (32-bit value, 5-bit exception vector, originating unit) into a small FIFO so firmware can collect results at its own pace over the register interface.
- Keeps RISC-V-style sticky accrued exception flags and an overflow flag, and drives a level interrupt.

---
 rtl/fpu_rq_pkg.sv | 42 ++++
 rtl/fpu_rq_fifo.sv | 75 +++++++
 rtl/fpu_result_queue.sv | 106 ++++++++++
 tb/tb_fpu_result_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_rq_pkg.sv
// Shared types and helpers for the FPU result queue.
// Exception bit positions, unit codes, the queued entry layout and the unit encoder.
package fpu_rq_pkg;

    localparam int EXC_NV = 4;
    localparam int EXC_DZ = 3;
    localparam int EXC_OF = 2;
    localparam int EXC_UF = 1;
    localparam int EXC_NX = 0;

    localparam int NUM_UNITS = 11;

    localparam logic [3:0] UNIT_FCLASS  = 4'd0;
    localparam logic [3:0] UNIT_SGN_INJ = 4'd1;
    localparam logic [3:0] UNIT_CMP     = 4'd2;
    localparam logic [3:0] UNIT_MIN_MAX = 4'd3;
    localparam logic [3:0] UNIT_I2F     = 4'd4;
    localparam logic [3:0] UNIT_F2I     = 4'd5;
    localparam logic [3:0] UNIT_ADD_SUB = 4'd6;
    localparam logic [3:0] UNIT_MUL     = 4'd7;
    localparam logic [3:0] UNIT_FMA     = 4'd8;
    localparam logic [3:0] UNIT_DIV     = 4'd9;
    localparam logic [3:0] UNIT_SQRT    = 4'd10;
    localparam logic [3:0] UNIT_ILLEGAL = 4'd15;

    typedef struct packed {
        logic [3:0]  unit;
        logic [4:0]  exc;
        logic [31:0] data;
    } rq_entry_t;

    // Highest set bit wins; an all-zero vector encodes as fclass.
    function automatic logic [3:0] enc_unit(input logic [NUM_UNITS-1:0] v);
        logic [3:0] r;
        r = UNIT_FCLASS;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/fpu_rq_fifo.sv
// Synchronous FIFO of result entries; a full FIFO still accepts a push when a pop
// frees the slot in the same cycle, and a pop on an empty FIFO is ignored.
module fpu_rq_fifo
    import fpu_rq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             i_push,
    input  logic             i_pop,
    input  rq_entry_t        i_data,
    output rq_entry_t        o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count,
    output logic             o_push_ok,
    output logic             o_drop,
    output logic             o_empty_next
);

    localparam int PTR_W = $clog2(DEPTH);

    rq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [CNT_W-1:0] w_count_next;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop & ~w_empty;
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
        end
    end

    // Storage needs no reset: nothing is visible until the count says so.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty      = w_empty;
    assign o_full       = w_full;
    assign o_count      = r_count;
    assign o_push_ok    = w_push_ok;
    assign o_drop       = i_push & ~w_push_ok;
    assign o_empty_next = (w_count_next == '0);

endmodule

// File: rtl/fpu_result_queue.sv
// Captures completed FPU results into a FIFO for firmware, keeping sticky accrued
// exception flags, a drop overflow flag and a level interrupt.
module fpu_result_queue
    import fpu_rq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [NUM_UNITS-1:0] res_valid,
    input  logic [31:0]          res_data,
    input  logic [4:0]           res_exc,
    input  logic                 illegal_op,
    input  logic                 pop,
    input  logic                 clr_flags,
    input  logic [1:0]           irq_en,
    output logic [31:0]          head_data,
    output logic [4:0]           head_exc,
    output logic [3:0]           head_unit,
    output logic                 q_empty,
    output logic                 q_full,
    output logic [CNT_W-1:0]     q_count,
    output logic [4:0]           fflags,
    output logic                 overflow,
    output logic                 irq
);

    logic      w_any_v;
    logic      r_any_v_q;
    logic      w_push;
    rq_entry_t w_entry;
    rq_entry_t w_head;
    logic      w_push_ok;
    logic      w_drop;
    logic      w_empty_next;
    logic [4:0] w_fflags_next;
    logic      w_ovf_next;
    logic [4:0] r_fflags;
    logic      r_ovf;
    logic      r_irq;

    // Rising edge only, so a result held valid for several cycles lands once.
    assign w_any_v = (|res_valid) | illegal_op;
    assign w_push  = w_any_v & ~r_any_v_q;

    always_comb begin
        w_entry      = '0;
        w_entry.unit = enc_unit(res_valid);
        w_entry.exc  = res_exc;
        w_entry.data = res_data;
        if (illegal_op) begin
            w_entry             = '0;
            w_entry.unit        = UNIT_ILLEGAL;
            w_entry.exc[EXC_NV] = 1'b1;
        end
    end

    fpu_rq_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst_l        (rst_l),
        .i_push       (w_push),
        .i_pop        (pop),
        .i_data       (w_entry),
        .o_head       (w_head),
        .o_empty      (q_empty),
        .o_full       (q_full),
        .o_count      (q_count),
        .o_push_ok    (w_push_ok),
        .o_drop       (w_drop),
        .o_empty_next (w_empty_next)
    );

    // A clear coinciding with new information keeps the new information.
    always_comb begin
        w_fflags_next = clr_flags ? 5'b0 : r_fflags;
        if (w_push_ok) w_fflags_next = w_fflags_next | w_entry.exc;
        w_ovf_next = w_drop | (r_ovf & ~clr_flags);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_any_v_q <= 1'b0;
            r_fflags  <= '0;
            r_ovf     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_any_v_q <= w_any_v;
            r_fflags  <= w_fflags_next;
            r_ovf     <= w_ovf_next;
            r_irq     <= (irq_en[0] & ~w_empty_next) |
                         (irq_en[1] & ((|w_fflags_next) | w_ovf_next));
        end
    end

    assign head_data = w_head.data;
    assign head_exc  = w_head.exc;
    assign head_unit = w_head.unit;
    assign fflags    = r_fflags;
    assign overflow  = r_ovf;
    assign irq       = r_irq;

endmodule

// File: tb/tb_fpu_result_queue.sv
// Scoreboard bench for fpu_result_queue: expected entries are queued as stimulus is
// driven and compared against the head as the FIFO drains.
module tb_fpu_result_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_l;
    logic [10:0]      res_valid;
    logic [31:0]      res_data;
    logic [4:0]       res_exc;
    logic             illegal_op;
    logic             pop;
    logic             clr_flags;
    logic [1:0]       irq_en;
    logic [31:0]      head_data;
    logic [4:0]       head_exc;
    logic [3:0]       head_unit;
    logic             q_empty;
    logic             q_full;
    logic [CNT_W-1:0] q_count;
    logic [4:0]       fflags;
    logic             overflow;
    logic             irq;

    fpu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_exc    (res_exc),
        .illegal_op (illegal_op),
        .pop        (pop),
        .clr_flags  (clr_flags),
        .irq_en     (irq_en),
        .head_data  (head_data),
        .head_exc   (head_exc),
        .head_unit  (head_unit),
        .q_empty    (q_empty),
        .q_full     (q_full),
        .q_count    (q_count),
        .fflags     (fflags),
        .overflow   (overflow),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: entries are {unit[3:0], exc[4:0], data[31:0]}.
    logic [40:0] sb [$];
    logic [4:0]  m_fflags = '0;
    logic        m_ovf    = 1'b0;
    logic        m_irq    = 1'b0;
    logic        m_anyq   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [40:0] mk_entry(input logic [10:0] v, input logic ill,
                                             input logic [4:0] e, input logic [31:0] d);
        logic [3:0] u;
        if (ill) return {4'd15, 5'b10000, 32'd0};
        u = 4'd0;
        for (int i = 10; i >= 0; i--) begin
            if (v[i]) begin
                u = 4'(i);
                break;
            end
        end
        return {u, e, d};
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic step();
        logic        anyv, push, popok, acc, drop;
        logic [40:0] ent;
        logic [4:0]  addf;
        anyv  = (|res_valid) | illegal_op;
        push  = anyv & ~m_anyq;
        popok = pop && (sb.size() > 0);
        acc   = push && ((sb.size() < DEPTH) || popok);
        drop  = push && !acc;
        ent   = mk_entry(res_valid, illegal_op, res_exc, res_data);
        if (popok) void'(sb.pop_front());
        if (acc) sb.push_back(ent);
        addf = acc ? ent[36:32] : 5'b0;
        m_fflags = clr_flags ? addf : (m_fflags | addf);
        if (drop) m_ovf = 1'b1;
        else if (clr_flags) m_ovf = 1'b0;
        m_irq  = (irq_en[0] && sb.size() != 0) || (irq_en[1] && ((|m_fflags) || m_ovf));
        m_anyq = anyv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        logic [40:0] hexp;
        hexp = (sb.size() == 0) ? 41'd0 : sb[0];
        chk({tag, ".count"}, 64'(q_count), 64'(sb.size()));
        chk({tag, ".empty"}, 64'(q_empty), 64'(sb.size() == 0));
        chk({tag, ".full"},  64'(q_full),  64'(sb.size() == DEPTH));
        chk({tag, ".head"},  64'({head_unit, head_exc, head_data}), 64'(hexp));
        chk({tag, ".fflags"}, 64'(fflags), 64'(m_fflags));
        chk({tag, ".ovf"},   64'(overflow), 64'(m_ovf));
        chk({tag, ".irq"},   64'(irq), 64'(m_irq));
    endtask

    task automatic pulse(input logic [10:0] v, input logic [31:0] d, input logic [4:0] e);
        res_valid = v;
        res_data  = d;
        res_exc   = e;
        step();
        res_valid = '0;
        step();
    endtask

    task automatic model_reset();
        sb.delete();
        m_fflags = '0;
        m_ovf    = 1'b0;
        m_irq    = 1'b0;
        m_anyq   = 1'b0;
    endtask

    initial begin
        logic [31:0] last_data;
        int          guard;

        rst_l = 1'b0; res_valid = '0; res_data = '0; res_exc = '0;
        illegal_op = 1'b0; pop = 1'b0; clr_flags = 1'b0; irq_en = 2'b00;
        #12;
        chk("rst.empty", 64'(q_empty), 64'd1);
        chk("rst.full",  64'(q_full),  64'd0);
        chk("rst.count", 64'(q_count), 64'd0);
        chk("rst.head",  64'({head_unit, head_exc, head_data}), 64'd0);
        chk("rst.fflags", 64'(fflags), 64'd0);
        chk("rst.ovf",   64'(overflow), 64'd0);
        chk("rst.irq",   64'(irq), 64'd0);
        rst_l = 1'b1;
        @(posedge clk);
        #1;

        // Level-held valid is captured exactly once.
        res_valid = 11'h040; res_data = 32'h3F800000; res_exc = 5'b00001;
        step();
        chk("lvl.unit",   64'(head_unit), 64'd6);
        chk("lvl.data",   64'(head_data), 64'h3F800000);
        chk("lvl.fflags", 64'(fflags), 64'd1);
        chk("lvl.count",  64'(q_count), 64'd1);
        repeat (4) step();
        chk("lvl.count5", 64'(q_count), 64'd1);
        res_valid = '0;
        step();
        check_state("lvl");
        pop = 1'b1; step(); pop = 1'b0;
        check_state("lvl.pop");

        // Fill and drop.
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        irq_en = 2'b10;
        for (int i = 0; i < 5; i++) begin
            pulse(11'h200, 32'hD0 + 32'(i), 5'b0);
            if (i == 3) chk("fill.full4", 64'(q_full), 64'd1);
            check_state("fill");
        end
        chk("fill.ovf",   64'(overflow), 64'd1);
        chk("fill.count", 64'(q_count), 64'd4);
        chk("fill.irq",   64'(irq), 64'd1);

        // Push coinciding with pop on a full FIFO.
        res_valid = 11'h200; res_data = 32'hA6; pop = 1'b1;
        step();
        pop = 1'b0; res_valid = '0;
        chk("fp.count", 64'(q_count), 64'd4);
        chk("fp.ovf",   64'(overflow), 64'd1);
        step();
        last_data = '0;
        guard = 0;
        while (q_empty !== 1'b1 && guard < 8) begin
            check_state("drain");
            last_data = head_data;
            pop = 1'b1; step(); pop = 1'b0;
            guard++;
        end
        chk("drain.last",  64'(last_data), 64'hA6);
        chk("drain.empty", 64'(q_empty), 64'd1);

        // Illegal op overrides res_valid.
        illegal_op = 1'b1; res_valid = 11'h002; res_data = 32'hDEAD; res_exc = 5'b00011;
        step();
        chk("ill.unit", 64'(head_unit), 64'd15);
        chk("ill.data", 64'(head_data), 64'd0);
        chk("ill.exc",  64'(head_exc), 64'h10);
        chk("ill.nv",   64'(fflags[4]), 64'd1);
        illegal_op = 1'b0; res_valid = '0;
        step();
        pop = 1'b1; step(); pop = 1'b0;
        check_state("ill");

        // Clear racing a push: the incoming exceptions survive.
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        pulse(11'h001, 32'h11, 5'b00011);
        pop = 1'b1; step(); pop = 1'b0;
        chk("race.pre", 64'(fflags), 64'h03);
        res_valid = 11'h001; res_data = 32'h22; res_exc = 5'b00100; clr_flags = 1'b1;
        step();
        clr_flags = 1'b0; res_valid = '0;
        chk("race.fflags", 64'(fflags), 64'h04);
        step();
        pop = 1'b1; step();
        check_state("race.pop");
        step();
        pop = 1'b0;
        chk("race.emptypop", 64'(q_count), 64'd0);
        check_state("race.emptypop");

        // Asynchronous reset with content in flight.
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        irq_en = 2'b01;
        for (int i = 0; i < 3; i++) pulse(11'h010, 32'h40 + 32'(i), 5'b00001);
        chk("mid.count",  64'(q_count), 64'd3);
        chk("mid.fflags", 64'(fflags), 64'd1);
        chk("mid.irq",    64'(irq), 64'd1);
        rst_l = 1'b0;
        #2;
        chk("mid.rst.count", 64'(q_count), 64'd0);
        chk("mid.rst.empty", 64'(q_empty), 64'd1);
        chk("mid.rst.fflags", 64'(fflags), 64'd0);
        chk("mid.rst.irq",   64'(irq), 64'd0);
        model_reset();
        #2;
        rst_l = 1'b1;
        @(posedge clk);
        #1;
        check_state("post.rst");

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            res_valid  = ($urandom_range(0, 2) == 0) ? 11'($urandom) : 11'd0;
            illegal_op = ($urandom_range(0, 15) == 0);
            res_data   = $urandom;
            res_exc    = 5'($urandom);
            pop        = ($urandom_range(0, 2) == 0);
            clr_flags  = ($urandom_range(0, 9) == 0);
            irq_en     = 2'($urandom);
            step();
            check_state("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
